irq_arbiter: RTL and testbench

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_arbiter.sv | 131 +++++++++++++
 tb/tb_irq_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - edge-latched interrupt arbiter, lowest-index priority, request/serve handshake
// Optional IRQ_SYNC_EN: 2-flop synchroniser on every irq_src_i bit ahead of edge detection.
module irq_arbiter #(
    parameter int N_SRC = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic [N_SRC-1:0] irq_mask_i,
    input  logic             irq_ack_i,
    input  logic             irq_ret_i,
    output logic             irq_req_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_SRC-1:0] irq_pending_o
);

    localparam logic [31:0] CAUSE_BASE = 32'h1000_0010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] s_d_q;
    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] id_onehot;
    logic [3:0]       id_q, id_d;
    logic [3:0]       winner;
    logic             win_valid;
    logic             mask_at_id;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = irq_src_i;
`endif

    assign rise     = s & ~s_d_q;
    assign eligible = pending_q & irq_mask_i;

    // Scan from the top so the lowest eligible index is the last one written.
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                winner    = k[3:0];
                win_valid = 1'b1;
            end
        end
    end

    always_comb begin
        id_onehot  = '0;
        mask_at_id = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (id_q == k[3:0]) begin
                id_onehot[k] = 1'b1;
                mask_at_id   = irq_mask_i[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        clr     = '0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = REQ;
                    id_d    = winner;
                end
            end
            REQ: begin
                if (irq_ack_i) begin
                    state_d = SERV;
                    clr     = id_onehot;
                end else if (!mask_at_id) begin
                    state_d = IDLE;
                end
            end
            SERV: begin
                if (irq_ret_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new rise on the bit being cleared wins, so the edge is never lost.
    assign pending_d = (pending_q & ~clr) | rise;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            s_d_q     <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            s_d_q     <= s;
            id_q      <= id_d;
        end
    end

    assign irq_req_o     = (state_q == REQ);
    assign irq_cause_o   = CAUSE_BASE | {28'd0, id_q};
    assign irq_pending_o = pending_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - scoreboard bench for irq_arbiter: priority, masking, serve/return, reset
module tb_irq_arbiter;

`ifdef IRQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] irq_src_i;
    logic [15:0] irq_mask_i;
    logic        irq_ack_i;
    logic        irq_ret_i;
    logic        irq_req_o;
    logic [31:0] irq_cause_o;
    logic [15:0] irq_pending_o;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] exp_q[$];

    irq_arbiter #(.N_SRC(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .irq_src_i     (irq_src_i),
        .irq_mask_i    (irq_mask_i),
        .irq_ack_i     (irq_ack_i),
        .irq_ret_i     (irq_ret_i),
        .irq_req_o     (irq_req_o),
        .irq_cause_o   (irq_cause_o),
        .irq_pending_o (irq_pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input int bit_idx);
        irq_src_i[bit_idx] = 1'b1;
        step();
        irq_src_i[bit_idx] = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] exp;
        check({tag, "_req"}, {31'd0, irq_req_o}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_cause"}, irq_cause_o, exp);
        end
    endtask

    task automatic wait_req(input string tag, input int budget);
        for (int i = 0; i < budget && !irq_req_o; i++) step();
        pop_check(tag);
    endtask

    task automatic do_ack(input string tag);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check({tag, "_ack_drop"}, {31'd0, irq_req_o}, 32'd0);
    endtask

    task automatic do_ret();
        irq_ret_i = 1'b1;
        step();
        irq_ret_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i      = 1'b0;
        irq_src_i  = '0;
        irq_mask_i = 16'hFFFF;
        irq_ack_i  = 1'b0;
        irq_ret_i  = 1'b0;
        #3;
        check("rst_req", {31'd0, irq_req_o}, 32'd0);
        check("rst_cause", irq_cause_o, 32'h1000_0010);
        check("rst_pend", {16'd0, irq_pending_o}, 32'd0);
        step();
        step();
        rst_i = 1'b1;
        step();

        // Single source: exact latency, ack clears pending, cause holds in SERV
        irq_src_i[3] = 1'b1;
        step();
        irq_src_i[3] = 1'b0;
        repeat (SYNC) step();
        check("lat_pend", {16'd0, irq_pending_o}, 32'h0000_0008);
        check("lat_req_early", {31'd0, irq_req_o}, 32'd0);
        exp_q.push_back(32'h1000_0013);
        step();
        pop_check("src3");
        do_ack("src3");
        check("src3_pend_clr", {16'd0, irq_pending_o}, 32'd0);
        check("src3_serv_cause", irq_cause_o, 32'h1000_0013);
        do_ret();

        // Simultaneous sources: lowest index first
        irq_src_i = 16'h0024;
        exp_q.push_back(32'h1000_0012);
        exp_q.push_back(32'h1000_0015);
        step();
        irq_src_i = '0;
        wait_req("prio_a", 4 + SYNC);
        do_ack("prio_a");
        do_ret();
        wait_req("prio_b", 4);
        do_ack("prio_b");
        do_ret();

        // Masked source pends but does not request
        irq_mask_i = 16'hFFFD;
        pulse(1);
        repeat (3 + SYNC) step();
        check("mask_req", {31'd0, irq_req_o}, 32'd0);
        check("mask_pend", {16'd0, irq_pending_o}, 32'h0000_0002);
        irq_mask_i = 16'hFFFF;
        exp_q.push_back(32'h1000_0011);
        wait_req("unmask", 4);
        do_ack("unmask");
        do_ret();

        // No nesting: edge in SERV waits for the return
        exp_q.push_back(32'h1000_0014);
        pulse(4);
        wait_req("nest_a", 4 + SYNC);
        do_ack("nest_a");
        pulse(0);
        repeat (2 + SYNC) step();
        check("nest_req", {31'd0, irq_req_o}, 32'd0);
        check("nest_pend", {16'd0, irq_pending_o}, 32'h0000_0001);
        do_ret();
        check("nest_ret_req", {31'd0, irq_req_o}, 32'd0);
        exp_q.push_back(32'h1000_0010);
        step();
        pop_check("nest_b");
        do_ack("nest_b");
        do_ret();

        // Ack coincides with a fresh rise of the same source
        exp_q.push_back(32'h1000_0016);
        pulse(6);
        wait_req("coin_a", 4 + SYNC);
        irq_ack_i    = 1'b1;
        irq_src_i[6] = 1'b1;
        step();
        irq_ack_i    = 1'b0;
        irq_src_i[6] = 1'b0;
        repeat (SYNC) step();
        check("coin_req", {31'd0, irq_req_o}, 32'd0);
        check("coin_pend", {16'd0, irq_pending_o}, 32'h0000_0040);
        do_ret();
        exp_q.push_back(32'h1000_0016);
        wait_req("coin_b", 4);
        do_ack("coin_b");
        do_ret();

        // Level held high pends only once
        irq_src_i[7] = 1'b1;
        exp_q.push_back(32'h1000_0017);
        wait_req("level", 4 + SYNC);
        do_ack("level");
        do_ret();
        repeat (4) step();
        check("level_req", {31'd0, irq_req_o}, 32'd0);
        check("level_pend", {16'd0, irq_pending_o}, 32'd0);
        irq_src_i[7] = 1'b0;
        repeat (1 + SYNC) step();

        // Cause frozen in REQ; masking the winner withdraws, pending kept
        exp_q.push_back(32'h1000_0019);
        pulse(9);
        wait_req("frz_a", 4 + SYNC);
        pulse(0);
        repeat (1 + SYNC) step();
        check("frz_cause", irq_cause_o, 32'h1000_0019);
        check("frz_req", {31'd0, irq_req_o}, 32'd1);
        irq_mask_i = 16'hFDFF;
        step();
        check("wd_req", {31'd0, irq_req_o}, 32'd0);
        check("wd_pend", {16'd0, irq_pending_o}, 32'h0000_0201);
        exp_q.push_back(32'h1000_0010);
        wait_req("wd_b", 4);
        do_ack("wd_b");
        do_ret();
        irq_mask_i = 16'hFFFF;
        exp_q.push_back(32'h1000_0019);
        wait_req("wd_c", 4);
        do_ack("wd_c");
        do_ret();

        // ret ignored in REQ, ack ignored in IDLE
        exp_q.push_back(32'h1000_001B);
        pulse(11);
        wait_req("ign", 4 + SYNC);
        do_ret();
        check("ret_in_req", {31'd0, irq_req_o}, 32'd1);
        do_ack("ign");
        do_ret();
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        step();
        check("ack_in_idle", {31'd0, irq_req_o}, 32'd0);

        // Asynchronous reset while requesting
        exp_q.push_back(32'h1000_0013);
        pulse(3);
        wait_req("arst", 4 + SYNC);
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_req", {31'd0, irq_req_o}, 32'd0);
        check("arst_pend", {16'd0, irq_pending_o}, 32'd0);
        check("arst_cause", irq_cause_o, 32'h1000_0010);
        step();
        rst_i = 1'b1;
        step();

        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
